bus_timer: RTL

// Memory-mapped countdown timer that responds to the CPU's data-bus

---
 rtl/bus_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer driven by CPU data-bus accesses.
//
// Register map (word index addr[3:2]):
//   0 CTRL   RW  [0] EN, [2:1] MODE, [3] IM; upper bits read 0, not stored
//   1 PRESET RW  reload value for COUNT
//   2 COUNT  RO  current count (writes ignored)
//   3 --     reads 0, writes ignored
//
// Ports:
//   clk    in   rising-edge system clock
//   reset  in   asynchronous active-high reset, clears all state
//   addr   in   byte address inside the timer window (addr[1:0] ignored)
//   we     in   write strobe, sampled at posedge clk
//   wdata  in   write data
//   rdata  out  read data, combinational from addr
//   irq    out  interrupt request = irq_flag & CTRL.IM
module bus_timer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_PRESET = 2'd1;
    localparam logic [1:0] IDX_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO  = 2'd1;

    state_t      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;

    logic [1:0]  idx;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic        unused_addr;

    assign idx         = addr[3:2];
    assign wr_ctrl     = we && (idx == IDX_CTRL);
    assign wr_preset   = we && (idx == IDX_PRESET);
    assign ctrl_en     = ctrl_q[0];
    assign ctrl_mode   = ctrl_q[2:1];
    assign ctrl_im     = ctrl_q[3];
    // Byte-lane bits and any address bits above the window are don't-care.
    assign unused_addr = ^addr;

    assign irq = irq_flag_q & ctrl_im;

    always_comb begin
        rdata = 32'd0;
        case (idx)
            IDX_CTRL:   rdata = {28'd0, ctrl_q};
            IDX_PRESET: rdata = preset_q;
            IDX_COUNT:  rdata = count_q;
            default:    rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            if (wr_preset) begin
                preset_q <= wdata;
            end

            case (state_q)
                IDLE: begin
                    if (ctrl_en) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!ctrl_en) begin
                        state_q <= IDLE;
                    end else if (count_q == 32'd0) begin
                        state_q    <= INT;
                        irq_flag_q <= 1'b1;
                    end else begin
                        count_q <= count_q - 32'd1;
                    end
                end
                INT: begin
                    if (ctrl_mode == MODE_AUTO) begin
                        irq_flag_q <= 1'b0;
                        state_q    <= ctrl_en ? LOAD : IDLE;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Placed last so a CPU write to CTRL overrides both the one-shot
            // EN clear and any flag update made by the FSM on the same edge.
            if (wr_ctrl) begin
                ctrl_q     <= wdata[3:0];
                irq_flag_q <= 1'b0;
            end
        end
    end

endmodule
